// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between pN byte-stream
// requesters. Ownership is granted for a whole packet (ending with req_last).
// Round-robin arbitration happens only at packet boundaries.
// An owner that offers no byte for pTimeout consecutive cycles is evicted.
//
// Handshake: requester i raises req_stb[i] with req_data/req_last stable and
// holds them until a one-cycle req_ack[i]. The transmitter side receives a
// one-cycle tx_stb only when tx_ready was high. After every byte, one GAP cycle
// ignores tx_ready so the transmitter has time to drop it.
module uart_tx_arbiter #(
    parameter int pN       = 2,
    parameter int pTimeout = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [pN-1:0]   req_stb,
    input  logic [pN*8-1:0] req_data,
    input  logic [pN-1:0]   req_last,
    output logic [pN-1:0]   req_ack,
    output logic [pN-1:0]   grant,
    output logic            tx_stb,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            timeout_stb
);

    localparam int PW = $clog2(pN);
    // A zero timeout would give a zero-width counter; keep one bit in that case.
    localparam int CW = (pTimeout == 0) ? 1 : $clog2(pTimeout + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((pTimeout == 0) ? 0 : pTimeout - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(pN - 1);
    localparam logic [pN-1:0] ONE      = pN'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;      // last winner; also the current owner while granted
    logic [CW-1:0]   cnt_q;      // consecutive owner-idle cycles
    logic            last_q;     // byte in flight ends the packet
    logic [pN-1:0]   grant_q;
    logic [pN-1:0]   req_ack_q;
    logic            tx_stb_q;
    logic [7:0]      tx_data_q;
    logic            timeout_stb_q;

    logic            win_found_d;
    logic [PW-1:0]   win_idx_d;
    logic [PW-1:0]   cand;
    logic            own_stb;
    logic            own_last;
    logic [7:0]      own_data;

    assign own_stb  = req_stb[ptr_q];
    assign own_last = req_last[ptr_q];
    assign own_data = req_data[{ptr_q, 3'b000} +: 8];

    // Round-robin search from ptr+1 upward; scanning downward lets the nearest hit win.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand        = '0;
        for (int k = pN; k >= 1; k--) begin
            cand = PW'((int'(ptr_q) + k) % pN);
            if (req_stb[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    // Arbitration FSM with registered grant, strobes and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= PTR_RST;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            grant_q       <= '0;
            req_ack_q     <= '0;
            tx_stb_q      <= 1'b0;
            tx_data_q     <= '0;
            timeout_stb_q <= 1'b0;
        end else begin
            tx_stb_q      <= 1'b0;
            req_ack_q     <= '0;
            timeout_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        grant_q <= ONE << win_idx_d;
                        ptr_q   <= win_idx_d;
                        cnt_q   <= '0;
                        state_q <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (own_stb) begin
                        // An offered byte always beats a simultaneous expiry.
                        cnt_q <= '0;
                        if (tx_ready) begin
                            tx_data_q <= own_data;
                            tx_stb_q  <= 1'b1;
                            req_ack_q <= ONE << ptr_q;
                            last_q    <= own_last;
                            state_q   <= S_SEND;
                        end
                    end else if (pTimeout != 0) begin
                        if (cnt_q == CNT_LAST) begin
                            grant_q       <= '0;
                            timeout_stb_q <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (last_q) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_OWN;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign grant       = grant_q;
    assign tx_stb      = tx_stb_q;
    assign tx_data     = tx_data_q;
    assign timeout_stb = timeout_stb_q;

endmodule
